aes_shift_mix_ark: RTL
======================

AES_SHIFT_MIX_ARK -- requirements
Module: aes_shift_mix_ark

Interface
REQ-001 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- sys_en  in  1  global enable; low freezes every register.
- in_valid  in  1  input beat valid (SubBytes result).
- in_ready  out  1  stage accepts a beat this cycle.
- state_in  in  128  post-SubBytes state; byte i at [127-8i -: 8], row i%4, column i/4.
- round_key  in  128  round key, same byte order, sampled with the input beat.
- last_round  in  1  skip MixColumns for this beat.
- round_in  in  4  round tag, carried alongside the beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- state_out  out  128  ShiftRows, then MixColumns (if not last), then XOR with round_key.
- round_out  out  4  tag of the output beat.
REQ-002 SHALL have no parameters.

Function
REQ-003 SHALL be a two-stage valid/ready pipeline.
- S1 registers ShiftRows+MixColumns result, key, last flag and tag.
- S2 registers the AddRoundKey result and tag.
REQ-004 ShiftRows SHALL map out(r,c) = in(r,(c+r) mod 4).
REQ-005 MixColumns SHALL use the FIPS-197 matrix [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2] over GF(2^8), polynomial 0x11B; xtime = shift left, XOR 0x1B on carry.
REQ-006 When last_round=1, S1 SHALL register the ShiftRows output unmodified.
REQ-007 AddRoundKey SHALL be a bytewise XOR with the key captured in S1 from the same beat; a later change of round_key SHALL NOT affect an accepted beat.
REQ-008 Transfer rules:
- Input transfer occurs when in_valid & in_ready.
- Output transfer occurs when out_valid & out_ready.
- in_valid, state_in, round_key, last_round and round_in are sampled only on transfer.
REQ-009 Latency SHALL be 2 cycles from input transfer to out_valid; throughput one beat per cycle when out_ready=1.
REQ-010 Stage advance rules:
- S2 loads when S2 is empty or its beat transfers out.
- S1 loads when S1 is empty or S1 advances into S2.
- in_ready = sys_en & (S1 empty | S1 advancing), combinational; no skid buffer.
REQ-011 While out_valid=1 and out_ready=0, state_out and round_out SHALL hold stable; no beat is lost or duplicated.
REQ-012 With S1 and S2 both full and out_ready low, in_ready SHALL be 0.
REQ-013 sys_en=0 SHALL hold all registers and force in_ready=0; out_valid keeps its value, but no output transfer is counted.
REQ-014 Simultaneous output transfer and input transfer SHALL both complete in the same cycle, and ordering is preserved.

Reset
REQ-015 rst=1 at a clock edge SHALL clear the S1 and S2 valid bits, making out_valid=0 and in_ready=0 that cycle.
REQ-016 rst SHALL clear state_out and round_out to 0.
REQ-017 rst SHALL take priority over sys_en; in-flight beats mid-operation are discarded.
REQ-018 Data registers other than outputs need no reset.

Structure
REQ-019 Package aes_pkg SHALL hold the xtime function, the constant 8'h1B and the AES state width 128.
REQ-020 Combinational sub-module aes_mixcolumn (32-bit column in/out) SHALL be instantiated 4 times.
REQ-021 The ShiftRows byte permutation SHALL be inlined wiring.

Verification
REQ-022 Column check: column db 13 53 45, last_round=0, round_key=0 -> that column out 8e 4d a1 bc.
REQ-023 FIPS-197 round 1:
- state_in d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30
- key a0 fa fe 17 88 54 2c b1 23 a3 39 39 2a 6c 76 05
- required out a4 9c 7f f2 68 9f 35 2b 6b 5b ea 43 02 6a 50 49, 2 cycles after input transfer.
REQ-024 Final round, last_round=1:
- state_in e9 09 89 72 cb 31 07 5f 3d 32 7d 94 af 2e 2c b5
- key d0 14 f9 a8 c9 ee 25 89 e1 3f 0c c8 b6 63 0c a6
- required out 39 25 84 1d 02 dc 09 fb dc 11 85 97 19 6a 0b 32.
REQ-025 Back-to-back 8 beats, tags 1..8, out_ready=0 for cycles 3-6:
- in_ready drops after 2 beats are held.
- out_valid stays high with data stable.
- out sequence is tags 1..8 in order, none lost or duplicated.
REQ-026 Assert rst for 1 cycle with 2 beats in flight -> next cycle out_valid=0, state_out=0, round_out=0; the following beat emerges correctly 2 cycles after its transfer.
REQ-027 sys_en=0 for 3 cycles mid-stream -> in_ready=0, all outputs frozen; resume yields the correct beats.

Source files
------------

// File: rtl/aes_shift_mix_ark_pkg.sv
// Shared AES constants and the GF(2^8) doubling helper used by the
// ShiftRows/MixColumns/AddRoundKey pipeline.
package aes_pkg;

   localparam int         AES_W    = 128;
   localparam logic [7:0] AES_POLY = 8'h1B;

   typedef logic [AES_W-1:0] aes_state_t;
   typedef logic [3:0]       aes_tag_t;

   // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/aes_shift_mix_ark_if.sv
// Beat-level valid/ready bus of the round stage: input beat (state, key,
// last flag, tag) on one side, keyed round output on the other.
interface aes_shift_mix_ark_if;
   import aes_pkg::*;

   logic       in_valid;
   logic       in_ready;
   aes_state_t state_in;
   aes_state_t round_key;
   logic       last_round;
   aes_tag_t   round_in;
   logic       out_valid;
   logic       out_ready;
   aes_state_t state_out;
   aes_tag_t   round_out;

   modport slave (
      input  in_valid, state_in, round_key, last_round, round_in, out_ready,
      output in_ready, out_valid, state_out, round_out
   );

   modport master (
      output in_valid, state_in, round_key, last_round, round_in, out_ready,
      input  in_ready, out_valid, state_out, round_out
   );

endinterface

// File: rtl/aes_shift_mix_ark_mixcolumn.sv
// One MixColumns column: 4 bytes (row 0 in the MSBs) through the
// circulant matrix [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2] over GF(2^8).
module aes_mixcolumn
   import aes_pkg::*;
(
   input  logic [31:0] i_col,
   output logic [31:0] o_col
);

   logic [7:0] w_a0, w_a1, w_a2, w_a3;
   logic [7:0] w_x0, w_x1, w_x2, w_x3;

   assign w_a0 = i_col[31:24];
   assign w_a1 = i_col[23:16];
   assign w_a2 = i_col[15:8];
   assign w_a3 = i_col[7:0];

   assign w_x0 = xtime(w_a0);
   assign w_x1 = xtime(w_a1);
   assign w_x2 = xtime(w_a2);
   assign w_x3 = xtime(w_a3);

   // 3*a is expressed as xtime(a) ^ a
   assign o_col[31:24] = w_x0 ^ (w_x1 ^ w_a1) ^ w_a2 ^ w_a3;
   assign o_col[23:16] = w_a0 ^ w_x1 ^ (w_x2 ^ w_a2) ^ w_a3;
   assign o_col[15:8]  = w_a0 ^ w_a1 ^ w_x2 ^ (w_x3 ^ w_a3);
   assign o_col[7:0]   = (w_x0 ^ w_a0) ^ w_a1 ^ w_a2 ^ w_x3;

endmodule

// File: rtl/aes_shift_mix_ark.sv
// Two-stage AES round tail: S1 holds ShiftRows+MixColumns (bypassed on the
// final round) plus key and tag, S2 holds the AddRoundKey result.
module aes_shift_mix_ark
   import aes_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sys_en,
   aes_shift_mix_ark_if.slave   bus
);

   aes_state_t w_sr;
   aes_state_t w_mix;
   aes_state_t w_s1_d;

   logic       w_adv_p2;
   logic       w_ld_p1;
   logic       w_in_fire;

   logic       r_vld_p1;
   aes_state_t r_state_p1;
   aes_state_t r_key_p1;
   aes_tag_t   r_round_p1;

   logic       r_vld_p2;
   aes_state_t r_state_p2;
   aes_tag_t   r_round_p2;

   // Byte (r,c) sits at index r+4c; row r rotates left by r columns
   for (genvar c = 0; c < 4; c++) begin : g_sr_col
      for (genvar r = 0; r < 4; r++) begin : g_sr_row
         assign w_sr[AES_W-1-8*(r+4*c) -: 8] =
            bus.state_in[AES_W-1-8*(r+4*((c+r)%4)) -: 8];
      end
   end

   for (genvar c = 0; c < 4; c++) begin : g_mix
      aes_mixcolumn u_mixcolumn (
         .i_col (w_sr[AES_W-1-32*c -: 32]),
         .o_col (w_mix[AES_W-1-32*c -: 32])
      );
   end

   assign w_s1_d = bus.last_round ? w_sr : w_mix;

   assign w_adv_p2  = sys_en & (~r_vld_p2 | bus.out_ready);
   assign w_ld_p1   = sys_en & ~rst & (~r_vld_p1 | w_adv_p2);
   assign w_in_fire = bus.in_valid & w_ld_p1;

   assign bus.in_ready  = w_ld_p1;
   assign bus.out_valid = r_vld_p2;
   assign bus.state_out = r_state_p2;
   assign bus.round_out = r_round_p2;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld_p1 <= 1'b0;
         r_vld_p2 <= 1'b0;
      end else begin
         if (w_adv_p2) r_vld_p2 <= r_vld_p1;
         if (w_ld_p1)  r_vld_p1 <= bus.in_valid;
      end
   end

   // ---- S1: shifted/mixed state, key and tag of the accepted beat ----
   always_ff @(posedge clk) begin
      if (w_in_fire) begin
         r_state_p1 <= w_s1_d;
         r_key_p1   <= bus.round_key;
         r_round_p1 <= bus.round_in;
      end
   end

   // ---- S2: AddRoundKey result, held while downstream stalls ----
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state_p2 <= '0;
         r_round_p2 <= '0;
      end else if (w_adv_p2 && r_vld_p1) begin
         r_state_p2 <= r_state_p1 ^ r_key_p1;
         r_round_p2 <= r_round_p1;
      end
   end

endmodule
